// File: rtl/sic_dispatch_arbiter_pkg.sv
// Shared types for the sub-SIC dispatch path: packet layout, class tags and
// a helper for sizing round-robin pointers.
package sic_dispatch_arbiter_pkg;

   localparam int SIC_CLASS_W = 3;

   typedef logic [SIC_CLASS_W-1:0] sic_class_t;

   localparam sic_class_t SIC_CLASS_ALU     = 3'd0;
   localparam sic_class_t SIC_CLASS_BRANCH  = 3'd1;
   localparam sic_class_t SIC_CLASS_MEM     = 3'd2;
   localparam sic_class_t SIC_CLASS_SYSCALL = 3'd3;

   // Decoded instruction as seen by a sub-SIC; .valid is the delivery strobe.
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } sic_packet_t;

   // Pointer width for an N-way round robin; a single unit still gets one bit.
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sic_dispatch_arbiter_rr_arbiter.sv
// Pure combinational round-robin picker: first requester at or after ptr,
// wrapping modulo N. Shared with other small port-sharing arbiters.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] gnt_idx,
   output logic          gnt_any
);

   // Scan ptr, ptr+1, ... and keep only the first hit.
   always_comb begin
      int idx;
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!gnt_any && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = PW'(idx);
            gnt_any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sic_dispatch_arbiter.sv
// One-entry dispatch buffer between issue and the sub-SIC units. The held
// packet goes to one idle unit of its class (round robin) as a registered
// one-cycle strobe; flush drops the held packet and suppresses delivery.
module sic_dispatch_arbiter
   import sic_dispatch_arbiter_pkg::*;
#(
   parameter int NUM_SUB = 4,
   parameter int CLASS_W = SIC_CLASS_W,
   parameter logic [NUM_SUB-1:0][CLASS_W-1:0] UNIT_CLASS =
      {SIC_CLASS_MEM, SIC_CLASS_BRANCH, SIC_CLASS_ALU, SIC_CLASS_ALU},
   parameter int STALL_W = 32
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            flush,
   input  logic                            in_valid,
   input  sic_packet_t                     in_pkt,
   input  logic [CLASS_W-1:0]              in_class,
   output logic                            in_ready,
   input  logic [NUM_SUB-1:0]              sub_req,
   output sic_packet_t [NUM_SUB-1:0]       sub_pkt,
   output logic [STALL_W-1:0]              stall_cnt
);

   localparam int PTR_W = ptr_w(NUM_SUB);

   logic               hold_valid;
   sic_packet_t        hold_pkt;
   logic [CLASS_W-1:0] hold_class;
   logic [PTR_W-1:0]   rr_ptr;

   logic [NUM_SUB-1:0] eligible;
   logic [NUM_SUB-1:0] gnt;
   logic [PTR_W-1:0]   gnt_idx;
   logic               gnt_any;
   logic               grant_ok;
   logic               accept;
   logic [PTR_W-1:0]   rr_next;

   // A unit is a candidate when it asks, serves the held class and is not
   // already taking a strobe this cycle.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_SUB; i++)
         eligible[i] = hold_valid && sub_req[i] &&
                       (UNIT_CLASS[i] == hold_class) && !sub_pkt[i].valid;
   end

   rr_arbiter #(.N(NUM_SUB), .PW(PTR_W)) u_rr (
      .req     (eligible),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   assign grant_ok = gnt_any && !flush;
   assign in_ready = !flush && (!hold_valid || gnt_any);
   assign accept   = in_valid && in_ready;
   assign rr_next  = (int'(gnt_idx) == NUM_SUB - 1) ? '0 : gnt_idx + PTR_W'(1);

   // Holding register: refill may coincide with a drain for full rate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_valid <= 1'b0;
         hold_pkt   <= '0;
         hold_class <= '0;
      end else if (flush) begin
         hold_valid <= 1'b0;
      end else if (accept) begin
         hold_valid <= 1'b1;
         hold_pkt   <= in_pkt;
         hold_class <= in_class;
      end else if (grant_ok) begin
         hold_valid <= 1'b0;
      end
   end

   // Per-unit delivery: strobe only the granted unit; payload elsewhere may go stale.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sub_pkt <= '0;
      end else begin
         for (int i = 0; i < NUM_SUB; i++) begin
            sub_pkt[i].valid <= 1'b0;
            if (grant_ok && gnt[i]) begin
               sub_pkt[i].pc    <= hold_pkt.pc;
               sub_pkt[i].instr <= hold_pkt.instr;
               sub_pkt[i].valid <= 1'b1;
            end
         end
      end
   end

   // Round-robin pointer moves past the winner only on an actual grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        rr_ptr <= '0;
      else if (grant_ok) rr_ptr <= rr_next;
   end

   // Count cycles a held packet found no unit; frozen during flush, saturating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (hold_valid && !gnt_any && !flush && (stall_cnt != '1))
         stall_cnt <= stall_cnt + STALL_W'(1);
   end

endmodule

// File: tb/tb_sic_dispatch_arbiter.sv
// Directed checks of the dispatch arbiter with hand-derived expectations.
module tb_sic_dispatch_arbiter;
   import sic_dispatch_arbiter_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  flush = 1'b0;
   logic                  in_valid = 1'b0;
   sic_packet_t           in_pkt = '0;
   logic [2:0]            in_class = '0;
   logic                  in_ready;
   logic [3:0]            sub_req = '0;
   sic_packet_t [3:0]     sub_pkt;
   logic [3:0]            stall_cnt;

   int n_cmp = 0;
   int n_err = 0;

   sic_dispatch_arbiter #(.NUM_SUB(4), .CLASS_W(3), .STALL_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_pkt    (in_pkt),
      .in_class  (in_class),
      .in_ready  (in_ready),
      .sub_req   (sub_req),
      .sub_pkt   (sub_pkt),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] vld();
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = sub_pkt[i].valid;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [3:0] req);
      rst_n    = 1'b0;
      flush    = 1'b0;
      in_valid = 1'b0;
      in_pkt   = '0;
      in_class = '0;
      sub_req  = req;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [2:0] cls);
      in_valid     = v;
      in_pkt       = '0;
      in_pkt.pc    = pc;
      in_pkt.instr = pc ^ 32'hA5A5_0000;
      in_class     = cls;
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // 1: reset state, single ALU packet lands on unit0 two edges later
      do_reset(4'b1111);
      chk("t1_rst_ready", 64'(in_ready), 64'h1);
      chk("t1_rst_vld",   64'(vld()), 64'h0);
      chk("t1_rst_stall", 64'(stall_cnt), 64'h0);
      chk("t1_rst_rr",    64'(dut.rr_ptr), 64'h0);
      drive(1'b1, 32'h100, SIC_CLASS_ALU);
      chk("t1_in_ready", 64'(in_ready), 64'h1);
      tick();
      drive(1'b0, 32'h0, 3'd0);
      chk("t1_no_early_strobe", 64'(vld()), 64'h0);
      tick();
      chk("t1_strobe", 64'(vld()), 64'h1);
      chk("t1_pc",     64'(sub_pkt[0].pc), 64'h100);
      chk("t1_instr",  64'(sub_pkt[0].instr), 64'hA5A5_0100);
      chk("t1_rr",     64'(dut.rr_ptr), 64'h1);
      tick();
      chk("t1_pulse_end", 64'(vld()), 64'h0);

      // 2: back-to-back ALU packets split across units 0 and 1
      do_reset(4'b0011);
      drive(1'b1, 32'h200, SIC_CLASS_ALU);
      tick();
      drive(1'b1, 32'h204, SIC_CLASS_ALU);
      chk("t2_full_rate_ready", 64'(in_ready), 64'h1);
      tick();
      drive(1'b0, 32'h0, 3'd0);
      chk("t2_a_vld", 64'(vld()), 64'h1);
      chk("t2_a_pc",  64'(sub_pkt[0].pc), 64'h200);
      tick();
      chk("t2_b_vld", 64'(vld()), 64'h2);
      chk("t2_b_pc",  64'(sub_pkt[1].pc), 64'h204);
      tick();
      chk("t2_no_dup",  64'(vld()), 64'h0);
      chk("t2_drained", 64'(dut.hold_valid), 64'h0);

      // 3: MEM packet stalls until unit3 asks
      do_reset(4'b0111);
      drive(1'b1, 32'h300, SIC_CLASS_MEM);
      tick();
      drive(1'b0, 32'h0, 3'd0);
      chk("t3_stall_ready", 64'(in_ready), 64'h0);
      chk("t3_stall0", 64'(stall_cnt), 64'h0);
      tick();
      chk("t3_stall1", 64'(stall_cnt), 64'h1);
      tick();
      chk("t3_stall2", 64'(stall_cnt), 64'h2);
      sub_req = 4'b1111;
      #1;
      chk("t3_ready_on_grant", 64'(in_ready), 64'h1);
      tick();
      chk("t3_vld",        64'(vld()), 64'h8);
      chk("t3_pc",         64'(sub_pkt[3].pc), 64'h300);
      chk("t3_stall_hold", 64'(stall_cnt), 64'h2);

      // 4: BRANCH packet with rr_ptr=3 wraps to unit2
      do_reset(4'b1111);
      drive(1'b1, 32'h400, SIC_CLASS_BRANCH);
      tick();
      drive(1'b0, 32'h0, 3'd0);
      tick();
      chk("t4_first_vld", 64'(vld()), 64'h4);
      chk("t4_rr3",       64'(dut.rr_ptr), 64'h3);
      tick();
      drive(1'b1, 32'h404, SIC_CLASS_BRANCH);
      tick();
      drive(1'b0, 32'h0, 3'd0);
      tick();
      chk("t4_wrap_vld", 64'(vld()), 64'h4);
      chk("t4_wrap_pc",  64'(sub_pkt[2].pc), 64'h404);
      chk("t4_rr_after", 64'(dut.rr_ptr), 64'h3);

      // 5: flush a stalled packet while a new one is offered
      do_reset(4'b0000);
      drive(1'b1, 32'h500, SIC_CLASS_ALU);
      tick();
      flush   = 1'b1;
      sub_req = 4'b1111;
      drive(1'b1, 32'h5F0, SIC_CLASS_ALU);
      chk("t5_flush_ready", 64'(in_ready), 64'h0);
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0, 3'd0);
      chk("t5_no_strobe_a", 64'(vld()), 64'h0);
      chk("t5_hold_gone",   64'(dut.hold_valid), 64'h0);
      chk("t5_stall_held",  64'(stall_cnt), 64'h0);
      tick();
      chk("t5_no_strobe_b", 64'(vld()), 64'h0);
      drive(1'b1, 32'h510, SIC_CLASS_ALU);
      chk("t5_ready_again", 64'(in_ready), 64'h1);
      tick();
      drive(1'b0, 32'h0, 3'd0);
      tick();
      chk("t5_next_vld", 64'(vld()), 64'h1);
      chk("t5_next_pc",  64'(sub_pkt[0].pc), 64'h510);

      // 6: stall counter saturates, async reset mid-strobe clears everything
      do_reset(4'b0000);
      drive(1'b1, 32'h600, SIC_CLASS_ALU);
      tick();
      drive(1'b0, 32'h0, 3'd0);
      repeat (5) tick();
      chk("t6_stall5", 64'(stall_cnt), 64'h5);
      repeat (15) tick();
      chk("t6_saturated", 64'(stall_cnt), 64'hF);
      sub_req = 4'b1111;
      tick();
      chk("t6_strobe", 64'(vld()), 64'h1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_vld",   64'(vld()), 64'h0);
      chk("t6_rst_stall", 64'(stall_cnt), 64'h0);
      chk("t6_rst_rr",    64'(dut.rr_ptr), 64'h0);
      chk("t6_rst_hold",  64'(dut.hold_valid), 64'h0);
      rst_n = 1'b1;
      #1;
      chk("t6_ready_after", 64'(in_ready), 64'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
